// File: rtl/registro_pipeline_elastico.sv
// ---------------------------------------------------------------------------------------------
// registro_pipeline_elastico
//
// An elastic register pipeline with DEPTH stages of N-bit data. Each stage has its own valid bit.
// It places registered timing cuts between a producer and a consumer and carries backpressure
// through a valid/ready handshake. Empty stages (bubbles) are refilled from their predecessor
// even while later stages stall, so the pipeline can hold DEPTH words.
//
// Ports
//   CLK        in   clock; all state changes on the rising edge
//   RESET_N    in   synchronous reset, active-low (beats CE and FLUSH)
//   CE         in   global clock enable; 0 freezes every register
//   FLUSH      in   clears all valid bits on the next edge (only when CE=1); data regs hold
//   IN_DATA    in   upstream data word
//   IN_VALID   in   upstream word valid
//   IN_READY   out  the pipeline accepts IN_DATA this cycle
//   OUT_DATA   out  data register of the last stage
//   OUT_VALID  out  the last stage holds a valid word
//   OUT_READY  in   the consumer takes OUT_DATA this cycle (counted only when CE=1)
//   COUNT      out  number of valid stages (registered)
// ---------------------------------------------------------------------------------------------
module registro_pipeline_elastico #(
    parameter int unsigned N     = 12,
    parameter int unsigned DEPTH = 3
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         CE,
    input  logic                         FLUSH,
    input  logic [N-1:0]                 IN_DATA,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    output logic [N-1:0]                 OUT_DATA,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [N-1:0]     data_q [DEPTH];
    logic [N-1:0]     data_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    // Per-stage readiness and the value each stage would load.
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] src_v;
    logic [N-1:0]     src_data [DEPTH];

    // A stage can load when some stage at or after it is empty, or the consumer drains the end.
    always_comb begin
        logic hole;
        hole = OUT_READY;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hole   = hole | ~v_q[i];
            rdy[i] = hole;
        end
    end

    always_comb begin
        src_v[0]    = IN_VALID;
        src_data[0] = IN_DATA;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i]    = v_q[i-1];
            src_data[i] = data_q[i-1];
        end
    end

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (CE) begin
            if (FLUSH) begin
                v_d = '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rdy[i]) begin
                        v_d[i] = src_v[i];
                        // A bubble moving in leaves the old data in place.
                        if (src_v[i]) begin
                            data_d[i] = src_data[i];
                        end
                    end
                end
            end
        end

        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(v_d[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            v_q     <= '0;
            count_q <= '0;
            data_q  <= '{default: '0};
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    assign IN_READY  = CE & ~FLUSH & RESET_N & rdy[0];
    assign OUT_DATA  = data_q[DEPTH-1];
    assign OUT_VALID = v_q[DEPTH-1];
    assign COUNT     = count_q;

endmodule

// File: tb/tb_registro_pipeline_elastico.sv
module tb_registro_pipeline_elastico;

    localparam int N     = 12;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n, ce, flush, in_valid, out_ready;
    logic [N-1:0]  in_data;
    logic          in_ready, out_valid;
    logic [N-1:0]  out_data;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    registro_pipeline_elastico #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .CE        (ce),
        .FLUSH     (flush),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .COUNT     (count)
    );

    // Reference model: ordered list of words in flight, oldest first, each with its stage index.
    typedef struct {
        logic [N-1:0] d;
        int           pos;
    } item_t;

    item_t        mq[$];
    logic [N-1:0] m_out_data;
    logic [N-1:0] recv[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // A word advances one stage when the stage ahead is free after the word ahead has moved;
    // the oldest word at the last stage leaves when the consumer is ready.
    function automatic bit m_stage0_free(input bit ordy);
        int ahead = DEPTH;
        foreach (mq[k]) begin
            if (k == 0 && mq[k].pos == DEPTH - 1 && ordy) continue;
            ahead = (mq[k].pos + 1 < ahead) ? mq[k].pos + 1 : mq[k].pos;
        end
        return ahead > 0;
    endfunction

    task automatic m_update(input bit c, input bit f, input bit r, input bit iv,
                            input logic [N-1:0] id, input bit ordy);
        item_t nq[$];
        item_t it;
        int    ahead;
        int    np;
        if (!r) begin
            mq.delete();
            m_out_data = '0;
        end else if (c) begin
            if (f) begin
                mq.delete();
            end else begin
                ahead = DEPTH;
                foreach (mq[k]) begin
                    it = mq[k];
                    if (k == 0 && it.pos == DEPTH - 1 && ordy) continue;
                    np = (it.pos + 1 < ahead) ? it.pos + 1 : it.pos;
                    if (np == DEPTH - 1) m_out_data = it.d;
                    it.pos = np;
                    ahead  = np;
                    nq.push_back(it);
                end
                if (iv && ahead > 0) begin
                    it.d   = id;
                    it.pos = 0;
                    if (DEPTH == 1) m_out_data = id;
                    nq.push_back(it);
                end
                mq = nq;
            end
        end
    endtask

    // One clock cycle: drive, check against the model mid-cycle, clock, advance the model.
    task automatic cyc(input bit c, input bit f, input bit r, input bit iv,
                       input logic [N-1:0] id, input bit ordy);
        bit exp_valid;
        ce        = c;
        flush     = f;
        rst_n     = r;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #3;
        exp_valid = 1'b0;
        if (mq.size() > 0) exp_valid = (mq[0].pos == DEPTH - 1);
        check_val("in_ready", 32'(in_ready), 32'(c & ~f & r & m_stage0_free(ordy)));
        check_val("out_valid", 32'(out_valid), 32'(exp_valid));
        check_val("out_data", 32'(out_data), 32'(m_out_data));
        check_val("count", 32'(count), 32'(mq.size()));
        if (out_valid && ordy && c && r) recv.push_back(out_data);
        @(posedge clk);
        m_update(c, f, r, iv, id, ordy);
        #1;
    endtask

    task automatic idle(input int cycles, input bit ordy);
        for (int k = 0; k < cycles; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0, N'($urandom), ordy);
    endtask

    logic [N-1:0] s3_words [4];

    initial begin
        s3_words = '{12'hA5A, 12'h123, 12'h7FF, 12'h456};
        ce = 1'b0; flush = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        // Bring the DUT out of X before the model is trusted.
        @(posedge clk);
        @(posedge clk);
        m_update(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;

        // Reset with garbage inputs.
        for (int k = 0; k < 2; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1, N'($urandom), 1'b1);

        // Back-to-back streaming.
        recv.delete();
        for (int k = 1; k <= 10; k++) cyc(1'b1, 1'b0, 1'b1, 1'b1, N'(k), 1'b1);
        check_val("s2_steady_count", 32'(count), 32'(3));
        idle(4, 1'b1);
        check_val("s2_recv_size", 32'(recv.size()), 32'(10));
        foreach (recv[k]) check_val("s2_order", 32'(recv[k]), 32'(k + 1));

        // Stall: fourth word refused until the consumer drains.
        recv.delete();
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b1, 1'b1, s3_words[k], 1'b0);
        check_val("s3_full_count", 32'(count), 32'(3));
        cyc(1'b1, 1'b0, 1'b1, 1'b1, s3_words[3], 1'b1);
        idle(5, 1'b1);
        check_val("s3_recv_size", 32'(recv.size()), 32'(4));
        foreach (recv[k]) if (k < 4) check_val("s3_order", 32'(recv[k]), 32'(s3_words[k]));

        // Bubble collapsing.
        recv.delete();
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b1, (k % 2) == 0, N'(12'h100 + k), 1'b0);
        check_val("s4_packed_count", 32'(count), 32'(3));
        idle(4, 1'b1);
        check_val("s4_recv_size", 32'(recv.size()), 32'(3));
        foreach (recv[k]) check_val("s4_order", 32'(recv[k]), 32'(12'h100 + 2 * k));

        // Clock enable held low mid-stream.
        recv.delete();
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b1, 1'b1, N'(12'h200 + k), 1'b1);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1, N'(12'h2F0), 1'b1);
        for (int k = 3; k < 6; k++) cyc(1'b1, 1'b0, 1'b1, 1'b1, N'(12'h200 + k), 1'b1);
        idle(4, 1'b1);
        check_val("s5_recv_size", 32'(recv.size()), 32'(6));
        foreach (recv[k]) check_val("s5_order", 32'(recv[k]), 32'(12'h200 + k));

        // Flush with two words inside and a word offered.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 12'h301, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 12'h302, 1'b0);
        check_val("s6_pre_flush_count", 32'(count), 32'(2));
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 12'hBAD, 1'b0);
        check_val("s6_flush_count", 32'(count), 32'(0));
        check_val("s6_flush_valid", 32'(out_valid), 32'(0));
        idle(4, 1'b1);

        // Reset mid-stream.
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b1, 1'b1, N'(12'h400 + k), 1'b0);
        for (int k = 0; k < 2; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1, N'($urandom), 1'b1);
        check_val("s6_reset_count", 32'(count), 32'(0));
        check_val("s6_reset_data", 32'(out_data), 32'(0));

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            cyc(($urandom % 10) != 0, ($urandom % 40) == 0, ($urandom % 80) != 0,
                $urandom % 2, N'($urandom), ($urandom % 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
